// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit: forwarding selects and the
// mult/div interlock state encoding.
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_interlock.sv
// Mult/div occupancy tracker. A start in MD_IDLE loads the latency counter
// with N-1; the unit stays busy until the counter reaches 1, at which point
// done pulses for one cycle. Together with the start cycle itself, HI/LO
// readers are held exactly N cycles.
module md_interlock
    import hazard_unit_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_t        state;
    logic [CNT_W-1:0] count;

    // Occupancy FSM and latency countdown; a start while busy is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= MD_IDLE;
            count <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        state <= MD_BUSY;
                        count <= is_div ? DIV_LOAD : MUL_LOAD;
                    end
                end
                MD_BUSY: begin
                    count <= count - CNT_ONE;
                    if (count == CNT_ONE)
                        state <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign busy = !reset && (state == MD_BUSY);
    assign done = busy && (count == CNT_ONE);

    // The decode interlock should make an overlapping issue impossible.
    a_md_overlap: assert property (@(posedge clock) disable iff (reset)
        !(state == MD_BUSY && start));

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: stall/flush for load-use, decode-branch and HI/LO
// interlocks, plus E- and D-stage forwarding selects.
// Build option: HAZARD_FORWARD_EN enables forwarding; without it all
// forwarding selects are 0 and any in-flight RAW dependency stalls decode.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int RA_W       = 5,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [RA_W-1:0] d_rs,
    input  logic [RA_W-1:0] d_rt,
    input  logic            d_branch,
    input  logic            d_md_use,
    input  logic [RA_W-1:0] e_rs,
    input  logic [RA_W-1:0] e_rt,
    input  logic [RA_W-1:0] e_rf_wa,
    input  logic            e_rf_we,
    input  logic            e_is_load,
    input  logic            e_md_start,
    input  logic            e_md_is_div,
    input  logic [RA_W-1:0] m_rf_wa,
    input  logic            m_rf_we,
    input  logic            m_is_load,
    input  logic [RA_W-1:0] w_rf_wa,
    input  logic            w_rf_we,
    output logic            stall_f,
    output logic            stall_d,
    output logic            flush_e,
    output logic [1:0]      fwd_a_e,
    output logic [1:0]      fwd_b_e,
    output logic            fwd_a_d,
    output logic            fwd_b_d,
    output logic            md_busy,
    output logic            md_done
);

    // $0 is hardwired zero, so it never creates a dependency.
    function automatic logic match(input logic [RA_W-1:0] x, input logic [RA_W-1:0] y);
        return (x != '0) && (x == y);
    endfunction

    logic     md_stall, hz_stall;
    fwd_sel_t fwd_a, fwd_b;
    logic     fwd_ad, fwd_bd;

    md_interlock #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_interlock (
        .clock  (clock),
        .reset  (reset),
        .start  (e_md_start),
        .is_div (e_md_is_div),
        .busy   (md_busy),
        .done   (md_done)
    );

    // HI/LO readers wait for the unit, including the cycle the op issues.
    assign md_stall = d_md_use && (md_busy || e_md_start);

`ifdef HAZARD_FORWARD_EN
    logic lw_stall, br_stall;

    // E-stage ALU operand selects; the younger M result beats W.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (m_rf_we && match(m_rf_wa, e_rs))      fwd_a = FWD_MEM;
        else if (w_rf_we && match(w_rf_wa, e_rs)) fwd_a = FWD_WB;
        if (m_rf_we && match(m_rf_wa, e_rt))      fwd_b = FWD_MEM;
        else if (w_rf_we && match(w_rf_wa, e_rt)) fwd_b = FWD_WB;
    end

    // Only an ALU result is available in M early enough for the D compare.
    assign fwd_ad = d_branch && m_rf_we && !m_is_load && match(m_rf_wa, d_rs);
    assign fwd_bd = d_branch && m_rf_we && !m_is_load && match(m_rf_wa, d_rt);

    assign lw_stall = e_is_load && e_rf_we && (match(e_rf_wa, d_rs) || match(e_rf_wa, d_rt));
    assign br_stall = d_branch &&
                      ((e_rf_we && (match(e_rf_wa, d_rs) || match(e_rf_wa, d_rt))) ||
                       (m_is_load && (match(m_rf_wa, d_rs) || match(m_rf_wa, d_rt))));
    assign hz_stall = lw_stall || br_stall;
`else
    logic unused_nofwd;

    assign fwd_a  = FWD_RF;
    assign fwd_b  = FWD_RF;
    assign fwd_ad = 1'b0;
    assign fwd_bd = 1'b0;

    // Without bypassing, any pending E/M write to a D source must drain.
    // W needs no stall because the RF writes before it is read.
    assign hz_stall = (e_rf_we && (match(e_rf_wa, d_rs) || match(e_rf_wa, d_rt))) ||
                      (m_rf_we && (match(m_rf_wa, d_rs) || match(m_rf_wa, d_rt)));
    assign unused_nofwd = ^{d_branch, e_is_load, m_is_load, e_rs, e_rt, w_rf_wa, w_rf_we};
`endif

    assign stall_f = !reset && (hz_stall || md_stall);
    assign stall_d = stall_f;
    assign flush_e = stall_f;
    assign fwd_a_e = reset ? 2'b00 : fwd_a;
    assign fwd_b_e = reset ? 2'b00 : fwd_b;
    assign fwd_a_d = !reset && fwd_ad;
    assign fwd_b_d = !reset && fwd_bd;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit. Forwarding vectors are checked when built
// with HAZARD_FORWARD_EN, the stall-only vectors otherwise; the mult/div
// interlock and reset vectors apply to both builds.
module tb_hazard_unit;

    logic       clock, reset;
    logic [4:0] d_rs, d_rt, e_rs, e_rt, e_rf_wa, m_rf_wa, w_rf_wa;
    logic       d_branch, d_md_use, e_rf_we, e_is_load, e_md_start, e_md_is_div;
    logic       m_rf_we, m_is_load, w_rf_we;
    logic       stall_f, stall_d, flush_e, fwd_a_d, fwd_b_d, md_busy, md_done;
    logic [1:0] fwd_a_e, fwd_b_e;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_unit dut (
        .clock(clock), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_branch(d_branch), .d_md_use(d_md_use),
        .e_rs(e_rs), .e_rt(e_rt), .e_rf_wa(e_rf_wa), .e_rf_we(e_rf_we),
        .e_is_load(e_is_load), .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
        .m_rf_wa(m_rf_wa), .m_rf_we(m_rf_we), .m_is_load(m_is_load),
        .w_rf_wa(w_rf_wa), .w_rf_we(w_rf_we),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
        .md_busy(md_busy), .md_done(md_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        check({tag, ".stall_f"}, 32'(stall_f), 32'(exp));
        check({tag, ".stall_d"}, 32'(stall_d), 32'(exp));
        check({tag, ".flush_e"}, 32'(flush_e), 32'(exp));
    endtask

    task automatic chk_fwd(input string tag, input logic [1:0] ae, input logic [1:0] be,
                           input logic ad, input logic bd);
        check({tag, ".fwd_a_e"}, 32'(fwd_a_e), 32'(ae));
        check({tag, ".fwd_b_e"}, 32'(fwd_b_e), 32'(be));
        check({tag, ".fwd_a_d"}, 32'(fwd_a_d), 32'(ad));
        check({tag, ".fwd_b_d"}, 32'(fwd_b_d), 32'(bd));
    endtask

    task automatic clr();
        d_rs = 0; d_rt = 0; d_branch = 0; d_md_use = 0;
        e_rs = 0; e_rt = 0; e_rf_wa = 0; e_rf_we = 0; e_is_load = 0;
        e_md_start = 0; e_md_is_div = 0;
        m_rf_wa = 0; m_rf_we = 0; m_is_load = 0;
        w_rf_wa = 0; w_rf_we = 0;
    endtask

    // Advance to just after the next rising edge and clear all inputs.
    task automatic cyc();
        @(posedge clock);
        #1;
        clr();
    endtask

    // Issue a mult/div with a dependent HI/LO reader in D, then follow the
    // reader for n cycles, checking stall/busy/done each cycle.
    task automatic md_run(input string tag, input logic is_div, input int n);
        cyc();
        e_md_start = 1; e_md_is_div = is_div; d_md_use = 1;
        @(negedge clock);
        chk_stall({tag, ".issue"}, 1'b1);
        check({tag, ".issue.busy"}, 32'(md_busy), 32'd0);
        for (int k = 1; k <= n; k++) begin
            cyc();
            d_md_use = 1;
            @(negedge clock);
            check($sformatf("%s.c%0d.stall", tag, k), 32'(stall_f), 32'(k < n));
            check($sformatf("%s.c%0d.busy", tag, k), 32'(md_busy), 32'(k < n));
            check($sformatf("%s.c%0d.done", tag, k), 32'(md_done), 32'(k == n - 1));
        end
    endtask

    initial begin
        clock = 0;
        reset = 1;
        clr();

        // Reset with hazards present: everything forced low.
        cyc();
        e_rf_wa = 2; e_rf_we = 1; e_is_load = 1; d_rs = 2; d_md_use = 1; e_md_start = 1;
        m_rf_wa = 3; m_rf_we = 1; e_rs = 3; d_branch = 1; d_rt = 3;
        @(negedge clock);
        chk_stall("rst", 1'b0);
        chk_fwd("rst", 2'd0, 2'd0, 1'b0, 1'b0);
        check("rst.busy", 32'(md_busy), 32'd0);
        check("rst.done", 32'(md_done), 32'd0);
        cyc();
        reset = 0;
        @(negedge clock);
        check("post_rst.busy", 32'(md_busy), 32'd0);
        chk_stall("post_rst", 1'b0);

`ifdef HAZARD_FORWARD_EN
        // lw $2 in E, add $3,$2,$4 in D: one stall, then WB forward.
        cyc(); e_rf_wa = 2; e_rf_we = 1; e_is_load = 1; d_rs = 2; d_rt = 4;
        @(negedge clock); chk_stall("lw_use", 1'b1);
        cyc(); m_rf_wa = 2; m_rf_we = 1; m_is_load = 1; d_rs = 2; d_rt = 4;
        @(negedge clock); chk_stall("lw_use.bubble", 1'b0);
        cyc(); w_rf_wa = 2; w_rf_we = 1; e_rs = 2; e_rt = 4; e_rf_wa = 3; e_rf_we = 1;
        @(negedge clock); chk_stall("lw_use.exec", 1'b0);
        chk_fwd("lw_use.exec", 2'd1, 2'd0, 1'b0, 1'b0);
        cyc(); e_rf_wa = 2; e_rf_we = 1; e_is_load = 1; d_rt = 2;
        @(negedge clock); chk_stall("lw_use_rt", 1'b1);
        cyc(); e_rf_wa = 2; e_rf_we = 1; d_rs = 2;
        @(negedge clock); chk_stall("alu_e_no_stall", 1'b0);

        // M/W forwarding and M priority.
        cyc(); m_rf_wa = 5; m_rf_we = 1; w_rf_wa = 6; w_rf_we = 1; e_rs = 5; e_rt = 6;
        @(negedge clock); chk_fwd("fwd_mw", 2'd2, 2'd1, 1'b0, 1'b0);
        cyc(); m_rf_wa = 5; m_rf_we = 1; w_rf_wa = 5; w_rf_we = 1; e_rs = 5; e_rt = 5;
        @(negedge clock); chk_fwd("fwd_m_wins", 2'd2, 2'd2, 1'b0, 1'b0);
        cyc(); m_rf_wa = 5; w_rf_wa = 5; w_rf_we = 1; e_rs = 5;
        @(negedge clock); chk_fwd("fwd_m_no_we", 2'd1, 2'd0, 1'b0, 1'b0);

        // beq $7,$0 behind add $7.
        cyc(); d_branch = 1; d_rs = 7; e_rf_wa = 7; e_rf_we = 1;
        @(negedge clock); chk_stall("br_e", 1'b1);
        cyc(); d_branch = 1; d_rs = 7; m_rf_wa = 7; m_rf_we = 1;
        @(negedge clock); chk_stall("br_m", 1'b0);
        chk_fwd("br_m", 2'd0, 2'd0, 1'b1, 1'b0);
        cyc(); d_branch = 1; d_rt = 7; m_rf_wa = 7; m_rf_we = 1; m_is_load = 1;
        @(negedge clock); chk_stall("br_m_load", 1'b1);
        chk_fwd("br_m_load", 2'd0, 2'd0, 1'b0, 1'b0);
        cyc(); d_rs = 7; m_rf_wa = 7; m_rf_we = 1;
        @(negedge clock); chk_fwd("nobr_m", 2'd0, 2'd0, 1'b0, 1'b0);
        cyc(); d_branch = 1; e_rf_we = 1; e_is_load = 1; m_rf_we = 1; w_rf_we = 1;
        @(negedge clock); chk_stall("reg0", 1'b0);
        chk_fwd("reg0", 2'd0, 2'd0, 1'b0, 1'b0);
`else
        // Stall-only build: any E/M producer stalls D; no forwarding.
        cyc(); m_rf_wa = 2; m_rf_we = 1; d_rs = 2; e_rs = 2; e_rt = 2; d_branch = 1;
        @(negedge clock); chk_stall("raw_m", 1'b1);
        chk_fwd("raw_m", 2'd0, 2'd0, 1'b0, 1'b0);
        cyc(); e_rf_wa = 3; e_rf_we = 1; d_rt = 3;
        @(negedge clock); chk_stall("raw_e", 1'b1);
        cyc(); e_rf_wa = 2; e_rf_we = 1; e_is_load = 1; d_rs = 2; d_rt = 4;
        @(negedge clock); chk_stall("raw_lw_e", 1'b1);
        cyc(); m_rf_wa = 2; m_rf_we = 1; m_is_load = 1; d_rs = 2; d_rt = 4;
        @(negedge clock); chk_stall("raw_lw_m", 1'b1);
        cyc(); w_rf_wa = 4; w_rf_we = 1; d_rs = 4; e_rs = 4;
        @(negedge clock); chk_stall("raw_w", 1'b0);
        chk_fwd("raw_w", 2'd0, 2'd0, 1'b0, 1'b0);
        cyc(); m_rf_wa = 2; d_rs = 2;
        @(negedge clock); chk_stall("raw_m_no_we", 1'b0);
        cyc(); e_rf_we = 1; m_rf_we = 1; w_rf_we = 1; d_branch = 1;
        @(negedge clock); chk_stall("reg0", 1'b0);
`endif

        // HI/LO interlock: div holds 32 cycles, mult 4.
        md_run("div", 1'b1, 32);
        md_run("mult", 1'b0, 4);

        // Reset on cycle 10 of a div aborts it without a done pulse.
        cyc();
        e_md_start = 1; e_md_is_div = 1; d_md_use = 1;
        for (int k = 2; k <= 9; k++) begin
            cyc(); d_md_use = 1;
        end
        @(negedge clock);
        check("abort.pre.busy", 32'(md_busy), 32'd1);
        cyc(); d_md_use = 1; reset = 1;
        @(negedge clock);
        chk_stall("abort.in_rst", 1'b0);
        check("abort.in_rst.busy", 32'(md_busy), 32'd0);
        check("abort.in_rst.done", 32'(md_done), 32'd0);
        cyc(); d_md_use = 1; reset = 0;
        @(negedge clock);
        chk_stall("abort.after", 1'b0);
        check("abort.after.busy", 32'(md_busy), 32'd0);
        check("abort.after.done", 32'(md_done), 32'd0);
        for (int k = 0; k < 25; k++) begin
            cyc(); d_md_use = 1;
            @(negedge clock);
            check($sformatf("abort.idle%0d.done", k), 32'(md_done), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
